// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl
// Sequencing controller around a small up-counter: start/stop/pause control,
// a prescaled count enable, a programmable terminal value and one-shot or
// periodic operation. cnt, tick and the FSM state are registered; busy and
// done are decoded from the state register only.
//
// Command inputs (start, stop, pause) are plain levels sampled on every rising
// edge, with fixed priority stop > pause > start in every state. There is no
// handshake: a command takes effect on the edge it is sampled on and is not
// acknowledged.
module counter_timer_ctrl #(
    parameter int CNT_W = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             tick,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] period_q;
    logic [PRE_W-1:0] prescale_q;
    logic             mode_q;

    // Single FSM: state, count, prescaler, latched configuration and tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pre        <= '0;
            tick       <= 1'b0;
            period_q   <= '0;
            prescale_q <= '0;
            mode_q     <= 1'b0;
        end else begin
            // tick is a one-cycle pulse unless a terminal event re-arms it below.
            tick <= 1'b0;
            if (stop) begin
                state <= S_IDLE;
                cnt   <= '0;
                pre   <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        // pause outranks start, so start is ignored while pause is high.
                        if (!pause && start) begin
                            period_q   <= period;
                            prescale_q <= prescale;
                            mode_q     <= mode;
                            cnt        <= '0;
                            pre        <= '0;
                            state      <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            // cnt and pre freeze; a coinciding terminal event is dropped.
                            state <= S_PAUSED;
                        end else if (pre == prescale_q) begin
                            pre <= '0;
                            if (cnt == period_q) begin
                                tick <= 1'b1;
                                if (mode_q) begin
                                    cnt <= '0;
                                end else begin
                                    state <= S_DONE;
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            pre <= pre + PRE_W'(1);
                        end
                    end
                    S_PAUSED: begin
                        // Resume without reload; frozen cnt and pre carry on.
                        if (!pause && start) begin
                            state <= S_RUN;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Status flags decoded from the state register.
    always_comb begin
        busy      = (state == S_RUN) || (state == S_PAUSED);
        done      = (state == S_DONE);
        dbg_state = state;
    end

endmodule

// File: doc/counter_timer_ctrl.md
Name: counter_timer_ctrl

Overview:
- Sequencing controller for the free-running 4-bit up-counter datapath: adds start/stop/pause control, a prescaled count enable, a programmable terminal value, and one-shot or periodic operation.
- Owns the count register, holds the counter in a defined state outside active operation, and raises a terminal tick for downstream logic (LED strobes, timeouts).
- Sits between the control/switch interface and any consumer of the count value.

Parameters:
- CNT_W, 4, width of count value and period.
- PRE_W, 4, width of prescaler compare value.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  level sampled per cycle; begin (from IDLE/DONE) or resume (from PAUSED).
- stop  input  1  abort to IDLE.
- pause  input  1  freeze counting (RUN only).
- mode  input  1  0 = one-shot, 1 = periodic; sampled with start from IDLE/DONE.
- period  input  CNT_W  terminal count value; sampled with start from IDLE/DONE.
- prescale  input  PRE_W  enable divider: count advances every prescale+1 cycles; sampled with period.
- cnt  output  CNT_W  current count.
- busy  output  1  high in RUN or PAUSED.
- done  output  1  high in DONE.
- tick  output  1  one-cycle pulse on each terminal event.

Behaviour:
- States: IDLE, RUN, PAUSED, DONE. Encoding is free; all outputs are registered or decoded from state only.
- Reset: state=IDLE, cnt=0, internal prescaler pre=0, tick=0, done=0, busy=0, and latched period/prescale/mode=0.
- Command priority in every state: stop > pause > start.
- IDLE:
  - start=1: latch period, prescale, mode; cnt<=0; pre<=0; go RUN.
  - Otherwise hold with cnt=0.
- RUN:
  - Each cycle: if pre==prescale_q, then pre<=0 and en=1; else pre<=pre+1 and en=0.
  - en=1 and cnt!=period_q: cnt<=cnt+1.
  - en=1 and cnt==period_q, mode_q=1: cnt<=0 and tick<=1 for exactly one cycle; stay in RUN.
  - en=1 and cnt==period_q, mode_q=0: cnt holds period_q, tick<=1 one cycle, go DONE.
  - Count values never exceed period_q, so no natural wrap at 2^CNT_W unless period_q = all-ones.
  - Tick period (periodic mode) = (period_q+1)*(prescale_q+1) cycles.
  - First increment occurs prescale_q+1 cycles after the start edge.
- period_q=0: cnt stays 0; tick fires every prescale_q+1 cycles (periodic), or once then DONE (one-shot).
- pause=1 in RUN: go PAUSED; cnt and pre frozen; a terminal event coinciding with pause is suppressed (no tick, no increment).
- PAUSED:
  - start=1 and pause=0: return to RUN with no reload; cnt and pre resume from the frozen values.
  - pause held high: remain PAUSED.
  - stop: go IDLE.
- DONE:
  - done=1 and cnt=period_q held.
  - start=1: behaves as from IDLE (relatch, cnt<=0, go RUN), so done drops the next cycle.
- stop=1 in any state: next cycle state=IDLE, cnt=0, pre=0, tick=0.
- Input changes to period, prescale, or mode while busy have no effect until the next start from IDLE/DONE.
- start held continuously in RUN is ignored. In one-shot mode with start held, DONE lasts one cycle before restarting.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Test Plan:
- Reset then start=1 for one cycle, mode=1, period=3, prescale=0: cnt sequence 0,1,2,3,0,1,...; tick high in each cycle where cnt shows 0 after a wrap, every 4 cycles; busy=1.
- mode=0, period=5, prescale=2: cnt steps every 3 cycles, 0..5; on the terminal edge tick pulses once, done=1, cnt holds 5; no further ticks; busy=0.
- Periodic run, period=9: assert pause while cnt=4 for 10 cycles (cnt stays 4, no tick), then start: counting resumes 5,6,...; tick timing is shifted by exactly the paused duration.
- stop, pause, and start asserted together while in RUN at cnt=7: next cycle IDLE, cnt=0, busy=0, tick=0.
- period=0, prescale=0, periodic: tick high every cycle after the first; cnt=0 constant. Repeat with period=15, prescale=15: tick every 256 cycles.
- rst_n pulsed low asynchronously between clock edges during RUN at cnt=6: outputs zero immediately; after release, remains IDLE until start.
